// File: rtl/rs_shared_adder_rr.sv
// One WIDTH-bit adder shared round-robin among NUM_CH valid/ready requesters,
// with a registered, backpressured result port. Optional subtract mode via RS_ADD_SUB_EN.
module rs_shared_adder_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_CH-1:0]        req_valid_in,
    output logic [NUM_CH-1:0]        req_ready_out,
    input  logic [NUM_CH*WIDTH-1:0]  op_a_in,
    input  logic [NUM_CH*WIDTH-1:0]  op_b_in,
`ifdef RS_ADD_SUB_EN
    input  logic [NUM_CH-1:0]        sub_in,
    output logic                     res_sub_out,
`endif
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [CH_W-1:0]          res_ch_out,
    output logic [WIDTH-1:0]         res_sum_out,
    output logic                     res_carry_out
);

    logic              r_res_valid;
    logic [CH_W-1:0]   r_res_ch;
    logic [WIDTH-1:0]  r_res_sum;
    logic              r_res_carry;
    logic [CH_W-1:0]   r_last_gnt;

    logic              w_issue_ok;
    logic              w_gnt_found;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_op_a [NUM_CH];
    logic [WIDTH-1:0]  w_op_b [NUM_CH];
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin;
    logic [WIDTH:0]    w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_op_a[gi] = op_a_in[gi*WIDTH +: WIDTH];
            assign w_op_b[gi] = op_b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A new result may be issued whenever the result slot is empty or being drained.
    assign w_issue_ok = !r_res_valid || res_ready_in;

    // Search starts one past the last granted channel and wraps modulo NUM_CH.
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(r_last_gnt) + k) % NUM_CH;
            if (!w_gnt_found && req_valid_in[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        if (w_gnt_found && w_issue_ok)
            req_ready_out[w_gnt_idx] = 1'b1;
    end

    assign w_xfer  = w_gnt_found && w_issue_ok;
    assign w_sel_a = w_op_a[w_gnt_idx];

`ifdef RS_ADD_SUB_EN
    logic r_res_sub;
    // Subtraction as a + ~b + 1, so the carry reads as "no borrow".
    assign w_cin   = sub_in[w_gnt_idx];
    assign w_b_eff = w_cin ? ~w_op_b[w_gnt_idx] : w_op_b[w_gnt_idx];

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_res_sub <= 1'b0;
        else if (w_xfer)
            r_res_sub <= w_cin;
    end

    assign res_sub_out = r_res_sub;
`else
    assign w_cin   = 1'b0;
    assign w_b_eff = w_op_b[w_gnt_idx];
`endif

    assign w_sum = {1'b0, w_sel_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_sum   <= '0;
            r_res_carry <= 1'b0;
            r_last_gnt  <= CH_W'(NUM_CH - 1);
        end else if (w_xfer) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= w_gnt_idx;
            r_res_sum   <= w_sum[WIDTH-1:0];
            r_res_carry <= w_sum[WIDTH];
            r_last_gnt  <= w_gnt_idx;
        end else if (res_ready_in) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid_out = r_res_valid;
    assign res_ch_out    = r_res_ch;
    assign res_sum_out   = r_res_sum;
    assign res_carry_out = r_res_carry;

endmodule

// File: tb/tb_rs_shared_adder_rr.sv
// Directed bench for rs_shared_adder_rr (WIDTH=8, NUM_CH=4); covers the
// RS_ADD_SUB_EN subtract vector when that macro is defined.
module tb_rs_shared_adder_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_ch;
    logic [7:0]  res_sum;
    logic        res_carry;
`ifdef RS_ADD_SUB_EN
    logic [3:0]  sub;
    logic        res_sub;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rs_shared_adder_rr #(.WIDTH(8), .NUM_CH(4)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .op_a_in       (op_a),
        .op_b_in       (op_b),
`ifdef RS_ADD_SUB_EN
        .sub_in        (sub),
        .res_sub_out   (res_sub),
`endif
        .res_valid_out (res_valid),
        .res_ready_in  (res_ready),
        .res_ch_out    (res_ch),
        .res_sum_out   (res_sum),
        .res_carry_out (res_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic v, input logic [1:0] ch,
                           input logic [7:0] s, input logic c);
        chk({tag, ".valid"}, 32'(res_valid), 32'(v));
        chk({tag, ".ch"},    32'(res_ch),    32'(ch));
        chk({tag, ".sum"},   32'(res_sum),   32'(s));
        chk({tag, ".carry"}, 32'(res_carry), 32'(c));
        $display("[TB] %s: valid=%0d ch=%0d sum=%02h carry=%0d", tag, res_valid, res_ch, res_sum, res_carry);
    endtask

    task automatic set_ops(input int ch, input logic [7:0] a, input logic [7:0] b);
        op_a[ch*8 +: 8] = a;
        op_b[ch*8 +: 8] = b;
    endtask

    logic [1:0] rr_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_sum [5] = '{8'h11, 8'h22, 8'h33, 8'hFE, 8'h11};
    logic       rr_c   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; req_valid = '0; res_ready = 1'b1; op_a = '0; op_b = '0;
`ifdef RS_ADD_SUB_EN
        sub = '0;
`endif
        // Reset state
        tick();
        tick();
        chk_res("reset", 1'b0, 2'd0, 8'h00, 1'b0);

        // Single request on channel 2
        rst = 1'b0;
        set_ops(2, 8'hF0, 8'h20);
        req_valid = 4'b0100;
        #1 chk("single.ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk_res("single", 1'b1, 2'd2, 8'h10, 1'b1);
        tick();
        chk_res("drain", 1'b0, 2'd2, 8'h10, 1'b1);

        // Fresh reset, then all channels request continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(0, 8'h10, 8'h01);
        set_ops(1, 8'h20, 8'h02);
        set_ops(2, 8'h30, 8'h03);
        set_ops(3, 8'hFF, 8'hFF);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("rr%0d.ready", i), 32'(req_ready), 32'(1) << rr_ch[i]);
            tick();
            chk_res($sformatf("rr%0d", i), 1'b1, rr_ch[i], rr_sum[i], rr_c[i]);
        end

        // Backpressure: ch0 result held for three cycles
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp%0d.ready", i), 32'(req_ready), 32'h0);
            tick();
            chk_res($sformatf("bp%0d", i), 1'b1, 2'd0, 8'h11, 1'b0);
        end
        res_ready = 1'b1;
        #1 chk("bp_release.ready", 32'(req_ready), 32'h2);
        tick();
        chk_res("bp_release", 1'b1, 2'd1, 8'h22, 1'b0);

        // Advance pointer to channel 3
        tick();
        chk_res("adv2", 1'b1, 2'd2, 8'h33, 1'b0);
        tick();
        chk_res("adv3", 1'b1, 2'd3, 8'hFE, 1'b1);

        // Wrap and skip: only channels 1 and 3 request
        req_valid = 4'b1010;
        #1 chk("wrap1.ready", 32'(req_ready), 32'h2);
        tick();
        chk_res("wrap1", 1'b1, 2'd1, 8'h22, 1'b0);
        #1 chk("wrap3.ready", 32'(req_ready), 32'h8);
        tick();
        chk_res("wrap3", 1'b1, 2'd3, 8'hFE, 1'b1);

        // Reset with a held result and pending requests
        req_valid = 4'b1111;
        res_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk_res("midrst", 1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b0;
        res_ready = 1'b1;
        #1 chk("postrst.ready", 32'(req_ready), 32'h1);
        tick();
        chk_res("postrst", 1'b1, 2'd0, 8'h11, 1'b0);
        req_valid = '0;
        tick();

        // Channel 1: a=05, b=07 (subtract when the option is built in)
        set_ops(1, 8'h05, 8'h07);
        req_valid = 4'b0010;
`ifdef RS_ADD_SUB_EN
        sub = 4'b0010;
`endif
        #1 chk("sub.ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
`ifdef RS_ADD_SUB_EN
        chk_res("sub", 1'b1, 2'd1, 8'hFE, 1'b0);
        chk("sub.flag", 32'(res_sub), 32'h1);
`else
        chk_res("add57", 1'b1, 2'd1, 8'h0C, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
